// File: rtl/fpu_pkg.sv
// fpu_pkg: op codes, dispatch FSM encoding and the qNaN result used by the FPU issue logic.
package fpu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;
endpackage

// File: rtl/fpu_watchdog.sv
// fpu_watchdog: counts WAIT cycles and flags expiry on the last allowed cycle.
module fpu_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  end
  assign expired_o = en_i && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/fpu_dispatch.sv
// fpu_dispatch: issues one FPU op at a time to add/mul/div and returns its registered result.
// FPU_TIMEOUT_EN adds a WAIT watchdog that returns qNaN with error after TIMEOUT_CYCLES.
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        add_start,
  output logic        add_sub,
  output logic        mul_start,
  output logic        div_start,
  input  logic        add_done,
  input  logic        mul_done,
  input  logic        div_done,
  input  logic [31:0] add_res,
  input  logic [31:0] mul_res,
  input  logic [31:0] div_res,
  input  logic        add_err,
  input  logic        add_ovf,
  input  logic        add_udf,
  input  logic        mul_err,
  input  logic        mul_ovf,
  input  logic        mul_udf,
  input  logic        div_err,
  input  logic        div_ovf,
  input  logic        div_udf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_error,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        busy
);
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fpu_dispatch: TIMEOUT_CYCLES must be 2..255");
  end
  state_t state_q, state_d;
  logic [1:0] op_q;
  logic [31:0] a_q, b_q, res_q;
  logic err_q, ovf_q, udf_q;
  logic sel_done, take, tmo;
  logic [34:0] sel_rsp;
  assign sel_done = op_q[1] ? (op_q[0] ? div_done : mul_done) : add_done;
  assign sel_rsp = op_q[1] ? (op_q[0] ? {div_res, div_err, div_ovf, div_udf} : {mul_res, mul_err, mul_ovf, mul_udf})
                           : {add_res, add_err, add_ovf, add_udf};
  assign take = (state_q == S_WAIT) && sel_done;
`ifdef FPU_TIMEOUT_EN
  logic expired;
  fpu_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk(clk),
    .rst(rst),
    .clr_i(state_q == S_ISSUE),
    .en_i(state_q == S_WAIT),
    .expired_o(expired)
  );
  assign tmo = expired && !sel_done;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = in_valid ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = (take || tmo) ? S_HOLD : S_WAIT;
      S_HOLD:  state_d = out_ready ? S_IDLE : S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q <= OP_ADD;
      a_q <= '0;
      b_q <= '0;
      {res_q, err_q, ovf_q, udf_q} <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && in_valid) {op_q, a_q, b_q} <= {in_op, in_a, in_b};
      if (take) {res_q, err_q, ovf_q, udf_q} <= sel_rsp;
      else if (tmo) {res_q, err_q, ovf_q, udf_q} <= {QNAN, 3'b100};
    end
  end
  assign in_ready = state_q == S_IDLE;
  assign busy = state_q != S_IDLE;
  assign out_valid = state_q == S_HOLD;
  assign add_start = (state_q == S_ISSUE) && !op_q[1];
  assign add_sub = add_start && op_q[0];
  assign mul_start = (state_q == S_ISSUE) && (op_q == OP_MUL);
  assign div_start = (state_q == S_ISSUE) && (op_q == OP_DIV);
  assign unit_a = a_q;
  assign unit_b = b_q;
  assign out_result = res_q;
  assign out_error = err_q;
  assign out_overflow = ovf_q;
  assign out_underflow = udf_q;
endmodule

// File: tb/tb_fpu_dispatch.sv
// tb_fpu_dispatch: randomized transaction-level check of fpu_dispatch against modelled FPU units.
module tb_fpu_dispatch;
  localparam int TO = 8;
`ifdef FPU_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
  logic [1:0] in_op = 0;
  logic [31:0] in_a = 0, in_b = 0, unit_a, unit_b, out_result;
  logic add_start, add_sub, mul_start, div_start;
  logic add_done = 0, mul_done = 0, div_done = 0;
  logic [31:0] add_res = 0, mul_res = 0, div_res = 0;
  logic add_err = 0, add_ovf = 0, add_udf = 0;
  logic mul_err = 0, mul_ovf = 0, mul_udf = 0;
  logic div_err = 0, div_ovf = 0, div_udf = 0;
  logic out_error, out_overflow, out_underflow;
  int n_cmp = 0, n_bad = 0;

  fpu_dispatch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .unit_a(unit_a), .unit_b(unit_b),
    .add_start(add_start), .add_sub(add_sub), .mul_start(mul_start), .div_start(div_start),
    .add_done(add_done), .mul_done(mul_done), .div_done(div_done),
    .add_res(add_res), .mul_res(mul_res), .div_res(div_res),
    .add_err(add_err), .add_ovf(add_ovf), .add_udf(add_udf),
    .mul_err(mul_err), .mul_ovf(mul_ovf), .mul_udf(mul_udf),
    .div_err(div_err), .div_ovf(div_ovf), .div_udf(div_udf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_error(out_error), .out_overflow(out_overflow), .out_underflow(out_underflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_units();
    {add_done, mul_done, div_done} = 3'b000;
  endtask

  task automatic drive_unit(input int u, input logic [31:0] r, input logic e, input logic o, input logic f);
    case (u)
      0: begin add_done = 1; add_res = r; {add_err, add_ovf, add_udf} = {e, o, f}; end
      1: begin mul_done = 1; mul_res = r; {mul_err, mul_ovf, mul_udf} = {e, o, f}; end
      default: begin div_done = 1; div_res = r; {div_err, div_ovf, div_udf} = {e, o, f}; end
    endcase
  endtask

  function automatic int unit_of(input logic [1:0] op);
    return op == 2'b10 ? 1 : op == 2'b11 ? 2 : 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_starts"}, {add_start, add_sub, mul_start, div_start}, 0);
    chk({tag, "_unit_a"}, unit_a, 0);
    chk({tag, "_unit_b"}, unit_b, 0);
    chk({tag, "_result"}, out_result, 0);
    chk({tag, "_flags"}, {out_error, out_overflow, out_underflow}, 0);
  endtask

  // lat = WAIT cycle on which the unit answers (0 = never); stall = HOLD cycles with out_ready low
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int lat,
                        input logic [31:0] res, input logic e, input logic o, input logic f,
                        input int stall, input bit junk);
    int u = unit_of(op);
    logic [31:0] er;
    logic [2:0] ef;
    bit hit = 0, tmo = 0;
    @(negedge clk);
    clear_units();
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    in_valid = 1; in_op = op; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = junk; in_op = 2'($urandom); in_a = $urandom; in_b = $urandom;
    chk("issue_add_start", add_start, 32'(op[1] == 1'b0));
    chk("issue_add_sub", add_sub, 32'(op == 2'b01));
    chk("issue_mul_start", mul_start, 32'(op == 2'b10));
    chk("issue_div_start", div_start, 32'(op == 2'b11));
    chk("issue_unit_a", unit_a, a);
    chk("issue_unit_b", unit_b, b);
    chk("issue_in_ready", in_ready, 0);
    chk("issue_busy", busy, 1);
    if (junk) drive_unit(u, $urandom, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 300 && !hit; k++) begin
      @(negedge clk);
      clear_units();
      chk("wait_out_valid", out_valid, 0);
      chk("wait_starts", {add_start, mul_start, div_start}, 0);
      chk("wait_in_ready", in_ready, 0);
      if (junk) drive_unit((u + 1 + int'($urandom_range(0, 1))) % 3, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
      if (k == lat) begin
        drive_unit(u, res, e, o, f);
        hit = 1;
      end else if (TMO_EN && k == TO) begin
        hit = 1;
        tmo = 1;
      end
    end
    chk("wait_bound", 32'(hit), 1);
    er = tmo ? 32'h7FC00000 : res;
    ef = tmo ? 3'b100 : {e, o, f};
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      clear_units();
      if (s == stall) in_valid = 0;
      out_ready = (s == stall);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_result", out_result, er);
      chk("hold_flags", {out_error, out_overflow, out_underflow}, 32'(ef));
      chk("hold_in_ready", in_ready, 0);
      chk("hold_busy", busy, 1);
    end
    @(negedge clk);
    out_ready = 0;
    chk("done_out_valid", out_valid, 0);
    chk("done_in_ready", in_ready, 1);
    chk("done_busy", busy, 0);
    chk("done_result_kept", out_result, er);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 0;
    run_op(2'b00, 32'h3F800000, 32'h40000000, 2, 32'h40400000, 0, 0, 0, 0, 0);
    run_op(2'b01, 32'h3F800000, 32'h40000000, 2, 32'hBF800000, 0, 0, 0, 0, 1);
    run_op(2'b11, 32'h3F800000, 32'h00000000, 3, 32'h7F800000, 1, 0, 0, 0, 0);
    run_op(2'b10, 32'h40000000, 32'h40400000, 1, 32'h40C00000, 0, 0, 0, 5, 0);
    // reset during WAIT, then a late done from the abandoned adder
    @(negedge clk);
    in_valid = 1; in_op = 2'b00; in_a = 32'h12345678; in_b = 32'h9ABCDEF0;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_reset_outputs("midrst");
    drive_unit(0, 32'h55555555, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    clear_units();
    chk("late_done_out_valid", out_valid, 0);
    chk("late_done_busy", busy, 0);
    chk("late_done_result", out_result, 0);
    @(negedge clk);
    chk("late_done_out_valid2", out_valid, 0);
    if (TMO_EN) begin
      run_op(2'b11, 32'h3F800000, 32'h40000000, 0, 32'h0, 0, 0, 0, 1, 0);
      run_op(2'b11, 32'h3F800000, 32'h40000000, TO, 32'h3F000000, 0, 0, 1, 0, 0);
    end
    for (int i = 0; i < 40; i++)
      run_op(2'($urandom), $urandom, $urandom, int'($urandom_range(1, 6)), $urandom,
             1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
